// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory responder on the snoop bus
package mem_bus_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int WORD_OFFSET = 2;
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_REQ,
    RD_DRIVE,
    WR_WAIT,
    WR_DONE
  } mem_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return v + 16'(en && v != 16'hffff);
  endfunction
endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: snoop bus signals seen by the memory responder
interface main_mem_responder_if import mem_bus_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] Address_Com;
  logic [DATA_WIDTH-1:0] Data_Bus_Com_in;
  logic [DATA_WIDTH-1:0] Data_Bus_Com_out;
  logic Data_Bus_Com_oe;
  logic BusRd;
  logic BusRdX;
  logic Mem_wr;
  logic Mem_oprn_abort;
  logic Mem_snoop_req;
  logic Mem_snoop_gnt;
  logic Data_in_Bus;
  logic Mem_write_done;
  modport slave (
    input Address_Com, Data_Bus_Com_in, BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Mem_snoop_gnt,
    output Data_Bus_Com_out, Data_Bus_Com_oe, Mem_snoop_req, Data_in_Bus, Mem_write_done
  );
  modport master (
    output Address_Com, Data_Bus_Com_in, BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Mem_snoop_gnt,
    input Data_Bus_Com_out, Data_Bus_Com_oe, Mem_snoop_req, Data_in_Bus, Mem_write_done
  );
endinterface

// File: rtl/main_mem_responder_mem_array.sv
// mem_array: word store with synchronous write, combinational read and per-word valid bits
module mem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit
);
  logic [DATA_WIDTH-1:0] mem [1<<DEPTH_LOG2];
  logic [(1<<DEPTH_LOG2)-1:0] valid;
  // data words are deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // valid bits mark words that have ever been written since reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  assign rdata = mem[raddr];
  assign hit = valid[raddr];
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: memory-side fill/write-back responder on the snoop bus; MEM_STATS_EN adds rd/wr/abort counters
module main_mem_responder import mem_bus_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT = 4,
  parameter int WRITE_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  main_mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] abort_cnt
`endif
);
  localparam int MAX_LAT = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  mem_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:WORD_OFFSET] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata, rd_word;
  logic hit, we, rd_any, quit, unused_lsb;
  assign unused_lsb = ^bus.Address_Com[WORD_OFFSET-1:0];
  assign rd_any = bus.BusRd | bus.BusRdX;
  assign quit = bus.Mem_oprn_abort | !rd_any;
  assign we = state == WR_WAIT && cnt == CW'(WRITE_LAT - 1);
  assign rd_word = hit ? rdata : DATA_WIDTH'({addr_q, {WORD_OFFSET{1'b0}}});
  mem_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .waddr(addr_q[WORD_OFFSET +: DEPTH_LOG2]),
    .wdata(wdata_q),
    .raddr(addr_q[WORD_OFFSET +: DEPTH_LOG2]),
    .rdata(rdata),
    .hit(hit)
  );
  // state register, latency counter and request capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n == state && (state == RD_WAIT || state == WR_WAIT)) ? cnt + 1'b1 : '0;
      addr_q <= state == IDLE ? bus.Address_Com[ADDR_WIDTH-1:WORD_OFFSET] : addr_q;
      wdata_q <= state == IDLE ? bus.Data_Bus_Com_in : wdata_q;
    end
  // next state and Moore outputs; oe additionally gated by the live grant
  always_comb begin
    state_n = state;
    bus.Mem_snoop_req = state == RD_REQ || state == RD_DRIVE;
    bus.Data_in_Bus = state == RD_DRIVE;
    bus.Data_Bus_Com_oe = state == RD_DRIVE && bus.Mem_snoop_gnt;
    bus.Data_Bus_Com_out = state == RD_DRIVE ? rd_word : '0;
    bus.Mem_write_done = state == WR_DONE;
    case (state)
      IDLE:     state_n = bus.Mem_wr ? WR_WAIT : rd_any ? RD_WAIT : IDLE;
      RD_WAIT:  state_n = quit ? IDLE : cnt == CW'(READ_LAT - 1) ? RD_REQ : RD_WAIT;
      RD_REQ:   state_n = quit ? IDLE : bus.Mem_snoop_gnt ? RD_DRIVE : RD_REQ;
      RD_DRIVE: state_n = rd_any ? RD_DRIVE : IDLE;
      WR_WAIT:  state_n = we ? WR_DONE : WR_WAIT;
      WR_DONE:  state_n = bus.Mem_wr ? WR_DONE : IDLE;
      default:  state_n = IDLE;
    endcase
  end
`ifdef MEM_STATS_EN
  logic rd_inc, ab_inc;
  assign rd_inc = state_n == RD_DRIVE && state != RD_DRIVE;
  assign ab_inc = (state == RD_WAIT || state == RD_REQ) && bus.Mem_oprn_abort;
  // saturating activity counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      rd_cnt <= sat_inc(rd_cnt, rd_inc);
      wr_cnt <= sat_inc(wr_cnt, we);
      abort_cnt <= sat_inc(abort_cnt, ab_inc);
    end
`endif
endmodule
